// File: rtl/dmem_responder_pkg.sv
// Shared types and defaults for the data-memory responder: access formats, FSM states and the
// default base address of word 0.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        FmtWord = 2'b00,
        FmtHalf = 2'b01,
        FmtByte = 2'b10,
        FmtIll  = 2'b11
    } dmem_fmt_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StWait = 2'b01,
        StResp = 2'b10
    } dmem_state_e;

    localparam logic [31:0] DefaultBaseAddr = 32'h1001_0000;
    localparam int unsigned WaitCntWidth    = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: merges store data into the addressed lane of a word and extracts a
// right-justified, zero-filled load value; flags half/word accesses that are misaligned.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [1:0]  fmt_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] old_word_i,
    input  logic [31:0] w_data_i,
    output logic [31:0] merged_word_o,
    output logic [31:0] load_data_o,
    output logic        misalign_o
);

    always_comb begin
        merged_word_o = old_word_i;
        load_data_o   = '0;
        misalign_o    = 1'b0;
        unique case (fmt_i)
            FmtWord: begin
                merged_word_o = w_data_i;
                load_data_o   = old_word_i;
                misalign_o    = (addr_lo_i != 2'b00);
            end
            FmtHalf: begin
                merged_word_o[{addr_lo_i[1], 4'b0000} +: 16] = w_data_i[15:0];
                load_data_o[15:0] = old_word_i[{addr_lo_i[1], 4'b0000} +: 16];
                misalign_o        = addr_lo_i[0];
            end
            FmtByte: begin
                merged_word_o[{addr_lo_i, 3'b000} +: 8] = w_data_i[7:0];
                load_data_o[7:0] = old_word_i[{addr_lo_i, 3'b000} +: 8];
            end
            FmtIll: begin
                misalign_o = 1'b0;
            end
            default: begin
                misalign_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for the multicycle CPU load/store port: accepts one request, waits
// WAIT_STATES cycles, then issues a one-cycle ready strobe with optional error.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = DefaultBaseAddr
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_r,
    input  logic        dmem_w,
    input  logic [1:0]  store_format_signal,
    input  logic [31:0] data_addr,
    input  logic [31:0] w_data,
    output logic [31:0] dmem_data,
    output logic        dmem_ready,
    output logic        dmem_err
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam logic [WaitCntWidth-1:0] WaitLast = WaitCntWidth'(WAIT_STATES);

    logic [31:0] mem_q [Depth];

    dmem_state_e             state_q;
    logic [WaitCntWidth-1:0] cnt_q;
    logic [31:0]             addr_q, wdata_q, data_q;
    logic [1:0]              fmt_q;
    logic                    rd_q, wr_q, ready_q, err_q;

    // The datapath looks at the live inputs while idle (needed for zero wait states) and at the
    // latched request in every other state.
    logic [31:0]           req_addr, req_wdata, off, old_word, merged_word, load_data;
    logic [1:0]            req_fmt;
    logic                  req_rd, req_wr, req_err, misalign, out_of_range, enter_resp;
    logic [ADDR_WIDTH-1:0] idx;

    assign req_addr  = (state_q == StIdle) ? data_addr           : addr_q;
    assign req_wdata = (state_q == StIdle) ? w_data              : wdata_q;
    assign req_fmt   = (state_q == StIdle) ? store_format_signal : fmt_q;
    assign req_rd    = (state_q == StIdle) ? dmem_r              : rd_q;
    assign req_wr    = (state_q == StIdle) ? dmem_w              : wr_q;

    assign off          = req_addr - BASE_ADDR;
    assign idx          = off[ADDR_WIDTH+1:2];
    assign out_of_range = (off >= 32'(4 * Depth));
    assign old_word     = mem_q[idx];

    dmem_lane_align u_lane_align (
        .fmt_i        (req_fmt),
        .addr_lo_i    (req_addr[1:0]),
        .old_word_i   (old_word),
        .w_data_i     (req_wdata),
        .merged_word_o(merged_word),
        .load_data_o  (load_data),
        .misalign_o   (misalign)
    );

    assign req_err = (req_rd & req_wr) | (req_fmt == FmtIll) | out_of_range | misalign;

    assign enter_resp = ((state_q == StIdle) && (dmem_r | dmem_w) && (WAIT_STATES == 0)) ||
                        ((state_q == StWait) && (cnt_q == WaitLast));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            fmt_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            data_q  <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (dmem_r | dmem_w) begin
                        addr_q  <= data_addr;
                        wdata_q <= w_data;
                        fmt_q   <= store_format_signal;
                        rd_q    <= dmem_r;
                        wr_q    <= dmem_w;
                        if (WAIT_STATES == 0) begin
                            state_q <= StResp;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= WaitCntWidth'(1);
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == WaitLast) begin
                        state_q <= StResp;
                    end else begin
                        cnt_q <= cnt_q + WaitCntWidth'(1);
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase

            if (enter_resp) begin
                ready_q <= 1'b1;
                err_q   <= req_err;
                if (req_err) begin
                    data_q <= '0;
                end else if (req_rd) begin
                    data_q <= load_data;
                end
            end
        end
    end

    // Stores commit on the edge leaving RESP; a reset on that edge discards them.
    always_ff @(posedge clk) begin
        if (!rst && (state_q == StResp) && req_wr && !req_err) begin
            mem_q[idx] <= merged_word;
        end
    end

    assign dmem_data  = data_q;
    assign dmem_ready = ready_q;
    assign dmem_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder: one instance with two wait states and one with none,
// both checked against a word-array reference model.
module tb_dmem_responder;

    localparam logic [31:0] Base  = 32'h1001_0000;
    localparam int unsigned Aw    = 10;
    localparam int unsigned Words = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_r [2];
    logic        req_w [2];
    logic [1:0]  fmt   [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] data  [2];
    logic        ready [2];
    logic        err   [2];

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_mem  [2][Words];
    logic [31:0] model_data [2];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(Aw), .WAIT_STATES(2), .BASE_ADDR(Base)) u_dut (
        .clk(clk), .rst(rst), .dmem_r(req_r[0]), .dmem_w(req_w[0]),
        .store_format_signal(fmt[0]), .data_addr(addr[0]), .w_data(wdata[0]),
        .dmem_data(data[0]), .dmem_ready(ready[0]), .dmem_err(err[0])
    );

    dmem_responder #(.ADDR_WIDTH(Aw), .WAIT_STATES(0), .BASE_ADDR(Base)) u_dut0 (
        .clk(clk), .rst(rst), .dmem_r(req_r[1]), .dmem_w(req_w[1]),
        .store_format_signal(fmt[1]), .data_addr(addr[1]), .w_data(wdata[1]),
        .dmem_data(data[1]), .dmem_ready(ready[1]), .dmem_err(err[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit model_err(input bit r, input bit w, input logic [1:0] f,
                                     input logic [31:0] a);
        logic [31:0] off;
        off = a - Base;
        return (r && w) || (f == 2'd3) || (off >= 4 * (2 ** Aw)) ||
               (f == 2'd1 && (a % 2) != 0) || (f == 2'd0 && (a % 4) != 0);
    endfunction

    // Updates the model for one access, then drives it and checks the response.
    task automatic txn(input int s, input bit r, input bit w, input logic [1:0] f,
                       input logic [31:0] a, input logic [31:0] wd, input string tag);
        bit          e;
        int          lat, k, lane, half;
        logic [31:0] word, mask;
        e = model_err(r, w, f, a);
        k    = int'((a - Base) / 4);
        lane = int'(a % 4);
        half = int'((a / 2) % 2);
        if (e) begin
            model_data[s] = '0;
        end else begin
            word = model_mem[s][k];
            if (r) begin
                case (f)
                    2'd0:    model_data[s] = word;
                    2'd1:    model_data[s] = (word >> (16 * half)) & 32'hFFFF;
                    default: model_data[s] = (word >> (8 * lane)) & 32'hFF;
                endcase
            end else begin
                case (f)
                    2'd0: begin
                        word = wd;
                    end
                    2'd1: begin
                        mask = 32'hFFFF << (16 * half);
                        word = (word & ~mask) | ((wd << (16 * half)) & mask);
                    end
                    default: begin
                        mask = 32'hFF << (8 * lane);
                        word = (word & ~mask) | ((wd << (8 * lane)) & mask);
                    end
                endcase
                model_mem[s][k] = word;
            end
        end
        req_r[s] = r;
        req_w[s] = w;
        fmt[s]   = f;
        addr[s]  = a;
        wdata[s] = wd;
        @(posedge clk);
        #1;
        req_r[s] = 1'b0;
        req_w[s] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ready[s] && lat < 20);
        check_eq({tag, "_lat"}, 32'(lat), (s == 0) ? 32'd3 : 32'd1);
        check_eq({tag, "_rdy"}, 32'(ready[s]), 32'd1);
        check_eq({tag, "_err"}, 32'(err[s]), 32'(e));
        check_eq({tag, "_data"}, data[s], model_data[s]);
        @(negedge clk);
        check_eq({tag, "_strobe"}, {30'd0, ready[s], err[s]}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          s, op, nready;
        logic [1:0]  f;
        logic [31:0] a;
        for (int i = 0; i < 2; i++) begin
            req_r[i] = 1'b0;
            req_w[i] = 1'b0;
            fmt[i]   = '0;
            addr[i]  = '0;
            wdata[i] = '0;
            model_data[i] = '0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check_eq("reset_data", data[i], 32'd0);
            check_eq("reset_flags", {30'd0, ready[i], err[i]}, 32'd0);
        end

        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < int'(Words); j++) begin
                txn(i, 1'b0, 1'b1, 2'd0, Base + 32'(4 * j), $urandom, "init");
            end
        end

        txn(0, 1'b0, 1'b1, 2'd0, 32'h1001_0004, 32'hDEAD_BEEF, "t1_sw");
        txn(0, 1'b1, 1'b0, 2'd0, 32'h1001_0004, 32'h0, "t1_lw");
        check_eq("t1_const", data[0], 32'hDEAD_BEEF);

        txn(0, 1'b0, 1'b1, 2'd0, 32'h1001_0008, 32'h1122_3344, "t2_sw");
        txn(0, 1'b0, 1'b1, 2'd2, 32'h1001_000A, 32'hFFFF_FFAA, "t2_sb");
        txn(0, 1'b1, 1'b0, 2'd0, 32'h1001_0008, 32'h0, "t2_lw");
        check_eq("t2_const_lw", data[0], 32'h11AA_3344);
        txn(0, 1'b1, 1'b0, 2'd2, 32'h1001_000B, 32'h0, "t2_lb");
        check_eq("t2_const_lb", data[0], 32'h0000_0011);

        txn(0, 1'b0, 1'b1, 2'd0, 32'h1001_0000, 32'h0, "t3_sw");
        txn(0, 1'b0, 1'b1, 2'd1, 32'h1001_0002, 32'h1234_BEEF, "t3_sh");
        txn(0, 1'b1, 1'b0, 2'd0, 32'h1001_0000, 32'h0, "t3_lw");
        check_eq("t3_const_lw", data[0], 32'hBEEF_0000);
        txn(0, 1'b1, 1'b0, 2'd1, 32'h1001_0002, 32'h0, "t3_lh");
        check_eq("t3_const_lh", data[0], 32'h0000_BEEF);

        txn(0, 1'b1, 1'b0, 2'd0, 32'h1001_0006, 32'h0, "t4_lw_mis");
        txn(0, 1'b0, 1'b1, 2'd1, 32'h1001_0001, 32'h5555, "t4_sh_mis");
        txn(0, 1'b0, 1'b1, 2'd3, 32'h1001_0004, 32'h7777_7777, "t4_ill");
        txn(0, 1'b1, 1'b0, 2'd0, 32'h1000_FFFC, 32'h0, "t4_below");
        txn(0, 1'b1, 1'b0, 2'd0, Base + 32'(4 * (2 ** Aw)), 32'h0, "t4_above");
        txn(0, 1'b0, 1'b1, 2'd0, Base + 32'(4 * (2 ** Aw)), 32'h9999_9999, "t4_sw_above");
        txn(0, 1'b1, 1'b1, 2'd0, 32'h1001_0004, 32'hCAFE_F00D, "t5_both");
        txn(0, 1'b1, 1'b0, 2'd0, 32'h1001_0004, 32'h0, "t4_keep4");
        check_eq("t4_const_keep4", data[0], 32'hDEAD_BEEF);
        txn(0, 1'b1, 1'b0, 2'd0, 32'h1001_0000, 32'h0, "t4_keep0");

        txn(1, 1'b0, 1'b1, 2'd0, 32'h1001_0004, 32'hA5A5_0F0F, "w0_sw");
        txn(1, 1'b1, 1'b0, 2'd0, 32'h1001_0004, 32'h0, "w0_lw");
        txn(1, 1'b0, 1'b1, 2'd2, 32'h1001_0005, 32'h0000_003C, "w0_sb");
        txn(1, 1'b1, 1'b0, 2'd2, 32'h1001_0005, 32'h0, "w0_lb");
        txn(1, 1'b1, 1'b0, 2'd1, 32'h1001_0003, 32'h0, "w0_err");

        for (int n = 0; n < 300; n++) begin
            s  = int'($urandom_range(0, 1));
            op = int'($urandom_range(0, 9));
            f  = ($urandom_range(0, 7) == 7) ? 2'd3 : 2'($urandom_range(0, 2));
            case ($urandom_range(0, 19))
                0:       a = Base - 32'(4 * $urandom_range(1, 64));
                1:       a = Base + 32'(4 * (2 ** Aw)) + 32'($urandom_range(0, 255));
                2:       a = $urandom;
                default: a = Base + 32'($urandom_range(0, 4 * Words - 1));
            endcase
            txn(s, (op == 0) || (op >= 6), op <= 5, f, a, $urandom, "rnd");
        end

        txn(0, 1'b1, 1'b0, 2'd0, 32'h1001_0010, 32'h0, "t6_pre");
        txn(1, 1'b1, 1'b0, 2'd0, 32'h1001_0010, 32'h0, "t6_pre0");
        if (model_data[0] == 32'd0) txn(0, 1'b1, 1'b0, 2'd0, 32'h1001_0004, 32'h0, "t6_pre4");
        req_r[0] = 1'b0;
        req_w[0] = 1'b1;
        fmt[0]   = 2'd0;
        addr[0]  = 32'h1001_0010;
        wdata[0] = 32'h1234_5678;
        @(posedge clk);
        #1;
        req_w[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            model_data[i] = '0;
            check_eq("t6_rst_data", data[i], 32'd0);
            check_eq("t6_rst_flags", {30'd0, ready[i], err[i]}, 32'd0);
        end
        rst = 1'b0;
        nready = 0;
        repeat (8) begin
            @(negedge clk);
            if (ready[0]) nready++;
        end
        check_eq("t6_no_ready", 32'(nready), 32'd0);
        txn(0, 1'b1, 1'b0, 2'd0, 32'h1001_0010, 32'h0, "t6_lw");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
